// File: rtl/ram_pkg.sv
// Shared types and constants for the byte-enabled simple dual-port RAM.
// Holds the clear-sweep FSM state encoding and the read-during-write mode values.
package ram_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    localparam int unsigned RDW_OLD = 0;
    localparam int unsigned RDW_NEW = 1;

endpackage

// File: rtl/ram_sdp_core.sv
// Byte-enabled storage array with one write port and one registered read port.
// Read data is read-before-write: a same-cycle write to the read address returns the old word.
module ram_sdp_core #(
    parameter int    AW        = 10,
    parameter int    DW        = 16,
    parameter int    BW        = 8,
    parameter string INIT_FILE = "",
    localparam int   NBE       = DW / BW
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           we,
    input  logic [AW-1:0]  waddr,
    input  logic [DW-1:0]  din,
    input  logic [NBE-1:0] wbe,
    input  logic           re,
    input  logic [AW-1:0]  raddr,
    output logic [DW-1:0]  rdata
);

    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < NBE; i++) begin
                if (wbe[i]) begin
                    mem[waddr][i*BW +: BW] <= din[i*BW +: BW];
                end
            end
        end
    end

    // Output register only updates on an accepted read, so it holds between reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/ram_sdp_be.sv
// Byte-enabled simple dual-port RAM with clear sweep, read-during-write forwarding
// and a configurable one- or two-cycle read latency.
module ram_sdp_be #(
    parameter int    AW           = 10,
    parameter int    DW           = 16,
    parameter int    BW           = 8,
    parameter int    RD_LAT       = 1,
    parameter int    RDW_NEW      = 0,
    parameter int    CLR_ON_RESET = 1,
    parameter string INIT_FILE    = "",
    localparam int   NBE          = DW / BW
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           we,
    input  logic [AW-1:0]  waddr,
    input  logic [DW-1:0]  din,
    input  logic [NBE-1:0] wbe,
    input  logic           re,
    input  logic [AW-1:0]  raddr,
    input  logic           clr,
    output logic [DW-1:0]  dout,
    output logic           rvalid,
    output logic           busy
);
    import ram_pkg::*;

    if ((DW % BW) != 0) begin : g_bad_dw
        $error("ram_sdp_be: DW must be a multiple of BW");
    end
    if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
        $error("ram_sdp_be: RD_LAT must be 1 or 2");
    end

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        unique case (state_q)
            IDLE: begin
                if (clr) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            CLEAR: begin
                if (cnt_q == '1) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= (CLR_ON_RESET != 0) ? CLEAR : IDLE;
            cnt_q   <= '0;
            busy_q  <= (CLR_ON_RESET != 0);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    assign busy = busy_q;

    // User traffic is only accepted in IDLE, and not in the cycle that requests a clear.
    logic accept, re_acc, we_acc, clearing;
    assign accept   = (state_q == IDLE) && !clr && !reset;
    assign re_acc   = accept && re;
    assign we_acc   = accept && we;
    assign clearing = (state_q == CLEAR) && !reset;

    logic           mem_we;
    logic [AW-1:0]  mem_addr;
    logic [DW-1:0]  mem_din;
    logic [NBE-1:0] mem_be;
    logic [DW-1:0]  core_rdata;

    assign mem_we   = clearing || we_acc;
    assign mem_addr = clearing ? cnt_q : waddr;
    assign mem_din  = clearing ? '0 : din;
    assign mem_be   = clearing ? '1 : wbe;

    ram_sdp_core #(
        .AW        (AW),
        .DW        (DW),
        .BW        (BW),
        .INIT_FILE (INIT_FILE)
    ) u_core (
        .clk   (clk),
        .reset (reset),
        .we    (mem_we),
        .waddr (mem_addr),
        .din   (mem_din),
        .wbe   (mem_be),
        .re    (re_acc),
        .raddr (raddr),
        .rdata (core_rdata)
    );

    // Forwarding context captured alongside each accepted read.
    logic           fwd_hit_q, fwd_hit_d;
    logic [DW-1:0]  fwd_din_q, fwd_din_d;
    logic [NBE-1:0] fwd_be_q, fwd_be_d;
    logic           v1_q, v1_d;

    always_comb begin
        fwd_hit_d = fwd_hit_q;
        fwd_din_d = fwd_din_q;
        fwd_be_d  = fwd_be_q;
        v1_d      = re_acc;
        if (re_acc) begin
            fwd_hit_d = (RDW_NEW == ram_pkg::RDW_NEW) && we_acc && (waddr == raddr);
            fwd_din_d = din;
            fwd_be_d  = wbe;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fwd_hit_q <= 1'b0;
            fwd_din_q <= '0;
            fwd_be_q  <= '0;
            v1_q      <= 1'b0;
        end else begin
            fwd_hit_q <= fwd_hit_d;
            fwd_din_q <= fwd_din_d;
            fwd_be_q  <= fwd_be_d;
            v1_q      <= v1_d;
        end
    end

    logic [DW-1:0] rd_merged;

    always_comb begin
        rd_merged = core_rdata;
        for (int i = 0; i < NBE; i++) begin
            if (fwd_hit_q && fwd_be_q[i]) begin
                rd_merged[i*BW +: BW] = fwd_din_q[i*BW +: BW];
            end
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        logic [DW-1:0] dout2_q, dout2_d;
        logic          v2_q;

        always_comb begin
            dout2_d = v1_q ? rd_merged : dout2_q;
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                dout2_q <= '0;
                v2_q    <= 1'b0;
            end else begin
                dout2_q <= dout2_d;
                v2_q    <= v1_q;
            end
        end

        assign dout   = dout2_q;
        assign rvalid = v2_q;
    end else begin : g_lat1
        assign dout   = rd_merged;
        assign rvalid = v1_q;
    end

endmodule

// File: tb/tb_ram_sdp_be.sv
// Bench for ram_sdp_be: two instances (RD_LAT=2/read-old and RD_LAT=1/read-new) share
// stimulus and are checked every cycle against a word-array model with a clear countdown.
module tb_ram_sdp_be;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        we = 1'b0, re = 1'b0, clr = 1'b0;
    logic [3:0]  waddr = '0, raddr = '0;
    logic [15:0] din = '0;
    logic [1:0]  wbe = '0;

    logic [15:0] dout_a, dout_b;
    logic        rvalid_a, rvalid_b, busy_a, busy_b;

    always #5 clk = ~clk;

    ram_sdp_be #(
        .AW (4), .DW (16), .BW (8), .RD_LAT (2), .RDW_NEW (0), .CLR_ON_RESET (1), .INIT_FILE ("")
    ) dut_a (
        .clk (clk), .reset (reset), .we (we), .waddr (waddr), .din (din), .wbe (wbe),
        .re (re), .raddr (raddr), .clr (clr), .dout (dout_a), .rvalid (rvalid_a), .busy (busy_a)
    );

    ram_sdp_be #(
        .AW (4), .DW (16), .BW (8), .RD_LAT (1), .RDW_NEW (1), .CLR_ON_RESET (1), .INIT_FILE ("")
    ) dut_b (
        .clk (clk), .reset (reset), .we (we), .waddr (waddr), .din (din), .wbe (wbe),
        .re (re), .raddr (raddr), .clr (clr), .dout (dout_b), .rvalid (rvalid_b), .busy (busy_b)
    );

    typedef struct {
        int          due;
        logic [15:0] data;
    } rd_t;

    typedef struct {
        logic        we;
        logic [3:0]  wa;
        logic [15:0] d;
        logic [1:0]  be;
        logic        re;
        logic [3:0]  ra;
        logic [15:0] eo;
        logic [15:0] en;
    } vec_t;

    rd_t         qa[$], qb[$];
    logic [15:0] mem_m [16];
    int          clr_left = 0;
    logic [15:0] last_a = '0, last_b = '0;
    int          cyc = 0;
    int          n_checks = 0, n_fail = 0;

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d,
                                          input logic [1:0] be);
        logic [15:0] m;
        m = old;
        if (be[0]) m[7:0] = d[7:0];
        if (be[1]) m[15:8] = d[15:8];
        return m;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic check_outputs();
        logic ev_a, ev_b;
        ev_a = 1'b0;
        ev_b = 1'b0;
        if (qa.size() > 0 && qa[0].due == cyc) begin
            ev_a   = 1'b1;
            last_a = qa[0].data;
            qa.delete(0);
        end
        if (qb.size() > 0 && qb[0].due == cyc) begin
            ev_b   = 1'b1;
            last_b = qb[0].data;
            qb.delete(0);
        end
        check("rvalid_a", {15'b0, rvalid_a}, {15'b0, ev_a});
        check("dout_a", dout_a, last_a);
        check("busy_a", {15'b0, busy_a}, {15'b0, clr_left != 0});
        check("rvalid_b", {15'b0, rvalid_b}, {15'b0, ev_b});
        check("dout_b", dout_b, last_b);
        check("busy_b", {15'b0, busy_b}, {15'b0, clr_left != 0});
    endtask

    // One clock: drive inputs, advance the model, then compare after the edge.
    task automatic step(input logic r, input logic w, input logic [3:0] wa, input logic [15:0] d,
                        input logic [1:0] be, input logic rd, input logic [3:0] ra,
                        input logic c, input logic use_tab, input logic [15:0] eo,
                        input logic [15:0] en);
        logic [15:0] old, nw;
        rd_t         e;
        reset = r; we = w; waddr = wa; din = d; wbe = be; re = rd; raddr = ra; clr = c;
        if (r) begin
            clr_left = 16;
            qa.delete();
            qb.delete();
            last_a = '0;
            last_b = '0;
        end else if (clr_left > 0) begin
            mem_m[16 - clr_left] = '0;
            clr_left--;
        end else if (c) begin
            clr_left = 16;
        end else begin
            if (rd) begin
                old = mem_m[ra];
                nw  = (w && wa == ra) ? merge(old, d, be) : old;
                e.due = cyc + 2; e.data = use_tab ? eo : old; qa.push_back(e);
                e.due = cyc + 1; e.data = use_tab ? en : nw;  qb.push_back(e);
            end
            if (w) mem_m[wa] = merge(mem_m[wa], d, be);
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle_cycle();
        step(1'b0, 1'b0, 4'd0, 16'h0, 2'b0, 1'b0, 4'd0, 1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    task automatic rand_cycle(input bit allow_ctl);
        logic [3:0] wa, ra;
        wa = 4'($urandom_range(0, 15));
        ra = ($urandom_range(0, 2) == 0) ? wa : 4'($urandom_range(0, 15));
        step(allow_ctl && ($urandom_range(0, 199) == 0), 1'($urandom), wa, 16'($urandom),
             2'($urandom), 1'($urandom), ra, allow_ctl && ($urandom_range(0, 49) == 0),
             1'b0, 16'h0, 16'h0);
    endtask

    // Counts busy cycles with random user traffic; the bound turns a stuck sweep into a miscount.
    task automatic count_busy(output int n);
        n = 0;
        for (int k = 0; k < 40 && busy_a; k++) begin
            rand_cycle(1'b0);
            n++;
        end
    endtask

    vec_t tab [14];
    int   n;

    initial begin
        tab[0]  = '{1'b1, 4'd3, 16'hABCD, 2'b11, 1'b0, 4'd0, 16'h0000, 16'h0000};
        tab[1]  = '{1'b1, 4'd3, 16'h1200, 2'b10, 1'b0, 4'd0, 16'h0000, 16'h0000};
        tab[2]  = '{1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'd3, 16'h12CD, 16'h12CD};
        tab[3]  = '{1'b1, 4'd5, 16'h1111, 2'b11, 1'b0, 4'd0, 16'h0000, 16'h0000};
        tab[4]  = '{1'b1, 4'd5, 16'h2222, 2'b11, 1'b1, 4'd5, 16'h1111, 16'h2222};
        tab[5]  = '{1'b1, 4'd5, 16'hEE77, 2'b01, 1'b1, 4'd5, 16'h2222, 16'h2277};
        tab[6]  = '{1'b1, 4'd5, 16'h9999, 2'b00, 1'b1, 4'd5, 16'h2277, 16'h2277};
        tab[7]  = '{1'b1, 4'd1, 16'h0101, 2'b11, 1'b0, 4'd0, 16'h0000, 16'h0000};
        tab[8]  = '{1'b1, 4'd2, 16'h0A0B, 2'b01, 1'b0, 4'd0, 16'h0000, 16'h0000};
        tab[9]  = '{1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'd1, 16'h0101, 16'h0101};
        tab[10] = '{1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'd2, 16'h000B, 16'h000B};
        tab[11] = '{1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'd3, 16'h12CD, 16'h12CD};
        tab[12] = '{1'b1, 4'd3, 16'hFFFF, 2'b11, 1'b0, 4'd0, 16'h0000, 16'h0000};
        tab[13] = '{1'b0, 4'd0, 16'h0000, 2'b00, 1'b0, 4'd0, 16'h0000, 16'h0000};

        @(negedge clk);
        // Reset then the power-on sweep must take exactly 16 busy cycles.
        step(1'b1, 1'b0, 4'd0, 16'h0, 2'b0, 1'b0, 4'd0, 1'b0, 1'b0, 16'h0, 16'h0);
        step(1'b1, 1'b0, 4'd0, 16'h0, 2'b0, 1'b0, 4'd0, 1'b0, 1'b0, 16'h0, 16'h0);
        count_busy(n);
        check("reset_sweep_len", 16'(n), 16'd16);
        step(1'b0, 1'b0, 4'd0, 16'h0, 2'b0, 1'b1, 4'd9, 1'b0, 1'b1, 16'h0000, 16'h0000);
        idle_cycle();
        idle_cycle();

        for (int i = 0; i < 14; i++) begin
            step(1'b0, tab[i].we, tab[i].wa, tab[i].d, tab[i].be, tab[i].re, tab[i].ra, 1'b0,
                 1'b1, tab[i].eo, tab[i].en);
        end
        idle_cycle();
        idle_cycle();

        // Clear while a read of addr 7 is still in flight.
        step(1'b0, 1'b1, 4'd7, 16'h00FF, 2'b11, 1'b0, 4'd0, 1'b0, 1'b0, 16'h0, 16'h0);
        step(1'b0, 1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd7, 1'b0, 1'b1, 16'h00FF, 16'h00FF);
        step(1'b0, 1'b1, 4'd7, 16'h1234, 2'b11, 1'b1, 4'd7, 1'b1, 1'b0, 16'h0, 16'h0);
        count_busy(n);
        check("clr_sweep_len", 16'(n), 16'd16);
        step(1'b0, 1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd7, 1'b0, 1'b1, 16'h0000, 16'h0000);
        idle_cycle();
        idle_cycle();

        // Reset halfway through a sweep restarts it from address 0.
        step(1'b1, 1'b0, 4'd0, 16'h0, 2'b0, 1'b0, 4'd0, 1'b0, 1'b0, 16'h0, 16'h0);
        for (int i = 0; i < 8; i++) idle_cycle();
        step(1'b1, 1'b0, 4'd0, 16'h0, 2'b0, 1'b0, 4'd0, 1'b0, 1'b0, 16'h0, 16'h0);
        count_busy(n);
        check("restart_sweep_len", 16'(n), 16'd16);

        for (int i = 0; i < 400; i++) rand_cycle(1'b1);
        for (int i = 0; i < 4; i++) idle_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ram_sdp_be.md
RAM_SDP_BE -- requirements
Module: ram_sdp_be

Interface
REQ-001 SHALL have parameter AW, default 10, address width; depth is 2^AW words.
REQ-002 SHALL have parameter DW, default 16, data width; DW SHALL be a multiple of BW.
REQ-003 SHALL have parameter BW, default 8, lane width; NBE = DW/BW.
REQ-004 SHALL have parameter RD_LAT, default 1, read latency; legal values are 1 or 2.
REQ-005 SHALL have parameter RDW_NEW, default 0; 0 = read-old on same-address collision, 1 = read-new (forwarded).
REQ-006 SHALL have parameter CLR_ON_RESET, default 1; 1 = zero the array after reset.
REQ-007 SHALL have parameter INIT_FILE, default "", a hex image loaded at simulation start when non-empty.
REQ-008 clk  in  1  single clock; all state updates on the rising edge.
REQ-009 reset  in  1  synchronous, active-high reset.
REQ-010 we  in  1  write strobe.
REQ-011 waddr  in  AW  write address.
REQ-012 din  in  DW  write data.
REQ-013 wbe  in  NBE  lane write enables; bit i covers din[i*BW +: BW].
REQ-014 re  in  1  read strobe.
REQ-015 raddr  in  AW  read address.
REQ-016 clr  in  1  runtime clear request, single-cycle pulse.
REQ-017 dout  out  DW  read data.
REQ-018 rvalid  out  1  dout carries new read data this cycle.
REQ-019 busy  out  1  a clear sweep is in progress.

Function
REQ-020 FSM SHALL have states IDLE and CLEAR; it holds a sweep counter of AW bits.
REQ-021 In IDLE with we=1, only lanes with wbe[i]=1 are written at waddr; the other lanes keep their contents.
REQ-022 In IDLE, re=1 in cycle t SHALL drive dout with mem[raddr] and rvalid=1 in cycle t+RD_LAT.
REQ-023 When no read completes, rvalid=0 and dout holds its last value.
REQ-024 When re=1 and we=1 target the same address in the same cycle:
 - RDW_NEW=0 returns the pre-write word.
 - RDW_NEW=1 returns the merged word: enabled lanes from din, other lanes from the old contents.
REQ-025 clr=1 in IDLE SHALL enter CLEAR next cycle with the counter at 0; we and re in that cycle are ignored.
REQ-026 In CLEAR, the FSM writes all-zero to mem[counter] each cycle and increments the counter, with busy=1.
REQ-027 In CLEAR, we, re and clr are ignored, and no new reads are launched.
REQ-028 After writing address 2^AW-1, the FSM SHALL return to IDLE with busy=0 on the next cycle; a full clear takes exactly 2^AW cycles.
REQ-029 A read accepted before entering CLEAR SHALL still complete at its scheduled cycle, using pre-clear data.
REQ-030 Counter wrap SHALL NOT occur; the exit decision uses counter == 2^AW-1.

Reset
REQ-031 Reset SHALL force dout=0 and rvalid=0, and SHALL flush all read-pipeline stages.
REQ-032 Reset SHALL force the FSM to CLEAR with counter=0 and busy=1 if CLR_ON_RESET=1, otherwise to IDLE with busy=0.
REQ-033 Reset asserted during CLEAR SHALL restart the sweep from address 0.
REQ-034 Array contents are not reset except through the clear sweep.
REQ-035 INIT_FILE contents are overwritten when CLR_ON_RESET=1.

Structure
REQ-036 Shared package ram_pkg SHALL hold:
 - the FSM state enum (IDLE, CLEAR);
 - the RDW mode constants (RDW_OLD=0, RDW_NEW=1).
REQ-037 Storage SHALL be a sub-module ram_sdp_core containing the byte-enabled array, one write port and one registered read port.
REQ-038 The top level SHALL contain the FSM, the RDW forwarding mux and the optional second read stage.
REQ-039 Elaboration SHALL error if DW % BW != 0 or if RD_LAT is not 1 or 2.

Verification (AW=4, DW=16, BW=8)
REQ-040 Reset with CLR_ON_RESET=1:
 - busy SHALL stay high for 16 cycles, then drop;
 - a subsequent read of addr 9 SHALL return 0x0000 at t+RD_LAT.
REQ-041 Write 0xABCD to addr 3 with wbe=11, then write 0x1200 with wbe=10, then read addr 3 -> dout=0x12CD with rvalid=1 exactly RD_LAT cycles after re.
REQ-042 mem[5]=0x1111, then same-cycle write 0x2222 (wbe=11) and read of addr 5:
 - RDW_NEW=0 -> 0x1111;
 - RDW_NEW=1 -> 0x2222.
REQ-043 Pulse clr while re for addr 7 (mem=0x00FF) is in flight with RD_LAT=2:
 - dout=0x00FF SHALL still arrive;
 - we/re during the 16 busy cycles have no effect;
 - a read of addr 7 after the clear returns 0x0000.
REQ-044 Assert reset at sweep count 8 -> busy stays high and the sweep restarts at 0, finishing 16 cycles after reset deasserts.
REQ-045 Issue reads on three consecutive cycles (addr 1, 2, 3) -> rvalid SHALL be high for three consecutive cycles carrying the matching data; after that, dout holds and rvalid=0.
